vga_zone_renderer: RTL

Parametrised VGA pixel engine that drives a 640x480 at 60 Hz display by default. It divides the horizontal active area into NUM_ZONES equal-width colour zones. Each zone has a 3-bit colour code, supplied per zone by the light/pattern FSM. It generates sync and the pixel clock internally, latches the zone codes only at frame boundaries (tear-free), and outputs sync and RGB aligned through a fixed registered pipeline.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing_gen.sv | 85 ++++++++
 rtl/vga_zone_renderer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, colour codes, channel expansion.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Zone colour codes, bit order {r,g,b}
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_WHITE = 3'b111;

  // Full-scale mask for one code bit; callers size-cast down to COLOR_BITS (<= 32).
  function automatic logic [31:0] expand_bit(input logic b);
    return b ? 32'hFFFF_FFFF : 32'h0;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, h/v counters and raw sync/active decode.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en_o,
  output logic active_o,
  output logic hs_n_o,
  output logic vs_n_o,
  output logic h_wrap_o,
  output logic frame_end_o,
  output logic vga_clk_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          vclk_q;

  assign pix_en_o = (div_q == DIV_LAST);

  // Next-state for divider and raster counters; counters move one pixel per pix_en
  always_comb begin
    div_d = pix_en_o ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (pix_en_o) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // State registers; VGA_CLK follows the new divider phase so it rises mid-pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      vclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      vclk_q <= (div_d >= DIV_HALF);
    end
  end

  assign active_o    = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_n_o      = !((h_q >= HS_BEG) && (h_q <= HS_END));
  assign vs_n_o      = !((v_q >= VS_BEG) && (v_q <= VS_END));
  assign h_wrap_o    = pix_en_o && (h_q == H_LAST);
  assign frame_end_o = h_wrap_o && (v_q == V_LAST);
  assign vga_clk_o   = vclk_q;

endmodule

// File: rtl/vga_zone_renderer.sv
// Zone renderer: divider-free zone tracking, frame-latched zone codes, one registered output stage.
module vga_zone_renderer import vga_pkg::*; #(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int CLK_DIV    = 2,
  parameter int NUM_ZONES  = 6,
  parameter int COLOR_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3*NUM_ZONES-1:0]  zone_codes,
  output logic                    hsync,
  output logic                    vsync,
  output logic [COLOR_BITS-1:0]   vga_red,
  output logic [COLOR_BITS-1:0]   vga_green,
  output logic [COLOR_BITS-1:0]   vga_blue,
  output logic                    VGA_CLK,
  output logic                    VGA_BLANK_N,
  output logic                    VGA_SYNC_N,
  output logic                    frame_start
);

  localparam int ZW  = H_ACTIVE / NUM_ZONES;
  localparam int ZIW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam int ZPW = $clog2(H_ACTIVE + 1);
  localparam logic [ZIW-1:0] ZI_LAST = ZIW'(NUM_ZONES - 1);
  localparam logic [ZPW-1:0] ZP_LAST = ZPW'(ZW - 1);

  logic pix_en, active, hs_n, vs_n, h_wrap, frame_end;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .pix_en_o   (pix_en),
    .active_o   (active),
    .hs_n_o     (hs_n),
    .vs_n_o     (vs_n),
    .h_wrap_o   (h_wrap),
    .frame_end_o(frame_end),
    .vga_clk_o  (VGA_CLK)
  );

  logic [ZIW-1:0]                 zone_idx_q, zone_idx_d;
  logic [ZPW-1:0]                 zone_px_q, zone_px_d;
  logic [NUM_ZONES-1:0][2:0]      shadow_q;
  logic                           frame_start_q;
  logic                           hsync_q, vsync_q, blank_n_q;
  logic [COLOR_BITS-1:0]          red_q, green_q, blue_q;
  logic [2:0]                     code;
  logic [COLOR_BITS-1:0]          red_d, green_d, blue_d;

  // Zone counters track the current hCount; the last zone keeps counting to absorb the remainder
  always_comb begin
    zone_idx_d = zone_idx_q;
    zone_px_d  = zone_px_q;
    if (pix_en) begin
      if (h_wrap) begin
        zone_idx_d = '0;
        zone_px_d  = '0;
      end else if (active) begin
        if (zone_px_q == ZP_LAST && zone_idx_q != ZI_LAST) begin
          zone_idx_d = zone_idx_q + 1'b1;
          zone_px_d  = '0;
        end else begin
          zone_px_d  = zone_px_q + 1'b1;
        end
      end
    end
  end

  assign code    = shadow_q[zone_idx_q];
  assign red_d   = active ? COLOR_BITS'(expand_bit(code[2])) : '0;
  assign green_d = active ? COLOR_BITS'(expand_bit(code[1])) : '0;
  assign blue_d  = active ? COLOR_BITS'(expand_bit(code[0])) : '0;

  // Zone counters, frame-boundary shadow load and its one-clk strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      zone_idx_q    <= '0;
      zone_px_q     <= '0;
      shadow_q      <= {NUM_ZONES{COL_BLACK}};
      frame_start_q <= 1'b0;
    end else begin
      zone_idx_q    <= zone_idx_d;
      zone_px_q     <= zone_px_d;
      frame_start_q <= frame_end;
      if (frame_end) shadow_q <= zone_codes;
    end
  end

  // Output stage: sync, blank and RGB share one pixel of latency
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_n_q <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else if (pix_en) begin
      hsync_q   <= hs_n;
      vsync_q   <= vs_n;
      blank_n_q <= active;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign VGA_BLANK_N = blank_n_q;
  assign vga_red     = red_q;
  assign vga_green   = green_q;
  assign vga_blue    = blue_q;
  assign VGA_SYNC_N  = 1'b0;
  assign frame_start = frame_start_q;

endmodule
